draw_rect_img: RTL and testbench

DRAW_RECT_IMG -- requirements
Module: draw_rect_img

---
 rtl/draw_rect_img_if.sv | 36 +++
 rtl/draw_rect_img.sv | 147 ++++++++++++++
 tb/tb_draw_rect_img.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/draw_rect_img_if.sv
// Pixel-stream bundle for draw_rect_img: position, timing in/out, image ROM port.
// The slave side is the drawing block; the master side drives timing and serves the ROM.
interface draw_rect_img_if;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic [11:0] pixel_addr;
    logic [11:0] rgb_pixel;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    modport master (
        output xpos, ypos, hcount_in, vcount_in, hsync_in, vsync_in,
               hblnk_in, vblnk_in, rgb_in, rgb_pixel,
        input  pixel_addr, hcount_out, vcount_out, hsync_out, vsync_out,
               hblnk_out, vblnk_out, rgb_out
    );

    modport slave (
        input  xpos, ypos, hcount_in, vcount_in, hsync_in, vsync_in,
               hblnk_in, vblnk_in, rgb_in, rgb_pixel,
        output pixel_addr, hcount_out, vcount_out, hsync_out, vsync_out,
               hblnk_out, vblnk_out, rgb_out
    );
endinterface

// File: rtl/draw_rect_img.sv
// Two-stage pipeline overlaying a colour-keyed image rectangle on the VGA stream.
// Stage 1 decides membership and addresses the ROM; stage 2 composites with its data.
module draw_rect_img #(
    parameter int unsigned RECT_WIDTH  = 64,
    parameter int unsigned RECT_HEIGHT = 64,
    parameter logic [11:0] TRANSPARENT = 12'h000
) (
    input  logic           clk,
    input  logic           rst,
    draw_rect_img_if.slave bus
);

    localparam logic [12:0] RECT_W13 = 13'(RECT_WIDTH);
    localparam logic [12:0] RECT_H13 = 13'(RECT_HEIGHT);

    logic        vsync_prev_r;
    logic [11:0] x_lat_r;
    logic [11:0] y_lat_r;
    logic        vsync_rise_s;

    logic [12:0] h13_s;
    logic [12:0] v13_s;
    logic [12:0] x13_s;
    logic [12:0] y13_s;
    logic        in_rect_s;
    logic [5:0]  col_s;
    logic [5:0]  row_s;

    logic [10:0] hcount_s1_r;
    logic [10:0] vcount_s1_r;
    logic        hsync_s1_r;
    logic        vsync_s1_r;
    logic        hblnk_s1_r;
    logic        vblnk_s1_r;
    logic [11:0] rgb_s1_r;
    logic        in_rect_s1_r;
    logic [11:0] pixel_addr_r;

    logic [10:0] hcount_out_r;
    logic [10:0] vcount_out_r;
    logic        hsync_out_r;
    logic        vsync_out_r;
    logic        hblnk_out_r;
    logic        vblnk_out_r;
    logic [11:0] rgb_out_r;
    logic [11:0] rgb_next_s;

    assign vsync_rise_s = bus.vsync_in & ~vsync_prev_r;

    // Frame-start position latch: sampled only on the vsync rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev_r <= 1'b0;
            x_lat_r      <= 12'h000;
            y_lat_r      <= 12'h000;
        end else begin
            vsync_prev_r <= bus.vsync_in;
            if (vsync_rise_s) begin
                x_lat_r <= bus.xpos;
                y_lat_r <= bus.ypos;
            end else begin
                x_lat_r <= x_lat_r;
                y_lat_r <= y_lat_r;
            end
        end
    end

    // Rectangle membership in 13 bits so a latch near 4095 cannot wrap back onto the screen
    always_comb begin
        h13_s     = {2'b00, bus.hcount_in};
        v13_s     = {2'b00, bus.vcount_in};
        x13_s     = {1'b0, x_lat_r};
        y13_s     = {1'b0, y_lat_r};
        in_rect_s = (h13_s >= x13_s) && (h13_s < (x13_s + RECT_W13)) &&
                    (v13_s >= y13_s) && (v13_s < (y13_s + RECT_H13));
        col_s     = bus.hcount_in[5:0] - x_lat_r[5:0];
        row_s     = bus.vcount_in[5:0] - y_lat_r[5:0];
    end

    // Stage 1: timing delay, membership flag and ROM address
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_s1_r  <= 11'd0;
            vcount_s1_r  <= 11'd0;
            hsync_s1_r   <= 1'b0;
            vsync_s1_r   <= 1'b0;
            hblnk_s1_r   <= 1'b0;
            vblnk_s1_r   <= 1'b0;
            rgb_s1_r     <= 12'h000;
            in_rect_s1_r <= 1'b0;
            pixel_addr_r <= 12'h000;
        end else begin
            hcount_s1_r  <= bus.hcount_in;
            vcount_s1_r  <= bus.vcount_in;
            hsync_s1_r   <= bus.hsync_in;
            vsync_s1_r   <= bus.vsync_in;
            hblnk_s1_r   <= bus.hblnk_in;
            vblnk_s1_r   <= bus.vblnk_in;
            rgb_s1_r     <= bus.rgb_in;
            in_rect_s1_r <= in_rect_s;
            pixel_addr_r <= {row_s, col_s};
        end
    end

    // Compositing: blanking forces black, keyed ROM pixels let the background through
    always_comb begin
        rgb_next_s = rgb_s1_r;
        if (hblnk_s1_r || vblnk_s1_r) begin
            rgb_next_s = 12'h000;
        end else if (in_rect_s1_r && (bus.rgb_pixel != TRANSPARENT)) begin
            rgb_next_s = bus.rgb_pixel;
        end else begin
            rgb_next_s = rgb_s1_r;
        end
    end

    // Stage 2: aligned output register
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out_r <= 11'd0;
            vcount_out_r <= 11'd0;
            hsync_out_r  <= 1'b0;
            vsync_out_r  <= 1'b0;
            hblnk_out_r  <= 1'b0;
            vblnk_out_r  <= 1'b0;
            rgb_out_r    <= 12'h000;
        end else begin
            hcount_out_r <= hcount_s1_r;
            vcount_out_r <= vcount_s1_r;
            hsync_out_r  <= hsync_s1_r;
            vsync_out_r  <= vsync_s1_r;
            hblnk_out_r  <= hblnk_s1_r;
            vblnk_out_r  <= vblnk_s1_r;
            rgb_out_r    <= rgb_next_s;
        end
    end

    assign bus.pixel_addr = pixel_addr_r;
    assign bus.hcount_out = hcount_out_r;
    assign bus.vcount_out = vcount_out_r;
    assign bus.hsync_out  = hsync_out_r;
    assign bus.vsync_out  = vsync_out_r;
    assign bus.hblnk_out  = hblnk_out_r;
    assign bus.vblnk_out  = vblnk_out_r;
    assign bus.rgb_out    = rgb_out_r;

endmodule

// File: tb/tb_draw_rect_img.sv
// Directed bench for draw_rect_img: vector table at a fixed latch, then line sweeps
// for latency, frame latching, clipping and reset behaviour.
module tb_draw_rect_img;

    logic        clk;
    logic        rst;
    logic [11:0] rom_val;
    int          total;
    int          bad;

    draw_rect_img_if bus ();

    draw_rect_img #(
        .RECT_WIDTH  (64),
        .RECT_HEIGHT (64),
        .TRANSPARENT (12'h000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rgb_pixel = rom_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic [11:0] rom;
        logic [11:0] exp_rgb;
        logic        chk_addr;
        logic [11:0] exp_addr;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic latch_pos(input logic [11:0] x, input logic [11:0] y);
        bus.xpos     = x;
        bus.ypos     = y;
        bus.vsync_in = 1'b0;
        tick();
        bus.vsync_in = 1'b1;
        tick();
        bus.vsync_in = 1'b0;
        tick();
    endtask

    // Streams hcount h0..h1 on line v; each output is checked two clocks after its input.
    task automatic sweep(input int v, input int h0, input int h1, input int x, input int y);
        int n;
        int h;
        int exp_rgb;
        n = h1 - h0 + 1;
        rom_val      = 12'h0F0;
        bus.rgb_in   = 12'hABC;
        bus.hblnk_in = 1'b0;
        bus.vblnk_in = 1'b0;
        bus.vcount_in = 11'(v);
        for (int i = 0; i <= n; i++) begin
            if (i < n) bus.hcount_in = 11'(h0 + i);
            tick();
            if (i >= 1) begin
                h = h0 + i - 1;
                exp_rgb = ((h >= x) && (h < x + 64) && (v >= y) && (v < y + 64)) ? 'h0F0 : 'hABC;
                chk("sweep_hcount", int'(bus.hcount_out), h);
                chk("sweep_rgb", int'(bus.rgb_out), exp_rgb);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rom_val = 12'h0F0;
        bus.xpos = 12'd0;      bus.ypos = 12'd0;
        bus.hcount_in = 11'd0; bus.vcount_in = 11'd0;
        bus.hsync_in = 1'b0;   bus.vsync_in = 1'b0;
        bus.hblnk_in = 1'b0;   bus.vblnk_in = 1'b0;
        bus.rgb_in = 12'h000;

        vecs[0]  = '{11'd100, 11'd50,  1'b0, 1'b0, 1'b0, 12'hABC, 12'h0F0, 12'h0F0, 1'b1, 12'h000};
        vecs[1]  = '{11'd99,  11'd50,  1'b0, 1'b0, 1'b0, 12'hABC, 12'h0F0, 12'hABC, 1'b0, 12'h000};
        vecs[2]  = '{11'd164, 11'd50,  1'b0, 1'b0, 1'b0, 12'hABC, 12'h0F0, 12'hABC, 1'b0, 12'h000};
        vecs[3]  = '{11'd163, 11'd50,  1'b1, 1'b0, 1'b0, 12'hABC, 12'h0F0, 12'h0F0, 1'b1, 12'h03F};
        vecs[4]  = '{11'd163, 11'd113, 1'b0, 1'b0, 1'b0, 12'hABC, 12'h0F0, 12'h0F0, 1'b1, 12'hFFF};
        vecs[5]  = '{11'd163, 11'd114, 1'b0, 1'b0, 1'b0, 12'hABC, 12'h0F0, 12'hABC, 1'b0, 12'h000};
        vecs[6]  = '{11'd120, 11'd49,  1'b0, 1'b0, 1'b0, 12'hABC, 12'h0F0, 12'hABC, 1'b0, 12'h000};
        vecs[7]  = '{11'd110, 11'd60,  1'b0, 1'b0, 1'b0, 12'h123, 12'h000, 12'h123, 1'b1, 12'h28A};
        vecs[8]  = '{11'd110, 11'd60,  1'b0, 1'b1, 1'b0, 12'h123, 12'h0F0, 12'h000, 1'b1, 12'h28A};
        vecs[9]  = '{11'd10,  11'd10,  1'b0, 1'b0, 1'b1, 12'hABC, 12'h0F0, 12'h000, 1'b0, 12'h000};
        vecs[10] = '{11'd120, 11'd70,  1'b1, 1'b0, 1'b0, 12'h5A5, 12'h0F0, 12'h0F0, 1'b1, 12'h514};
        vecs[11] = '{11'd0,   11'd0,   1'b0, 1'b0, 1'b0, 12'hFFF, 12'h0F0, 12'hFFF, 1'b0, 12'h000};
        vecs[12] = '{11'd100, 11'd113, 1'b0, 1'b0, 1'b0, 12'hABC, 12'h0F0, 12'h0F0, 1'b1, 12'hFC0};
        vecs[13] = '{11'd100, 11'd114, 1'b0, 1'b0, 1'b0, 12'hABC, 12'h0F0, 12'hABC, 1'b0, 12'h000};

        // Power-on reset state
        tick();
        tick();
        chk("reset_rgb", int'(bus.rgb_out), 0);
        chk("reset_hcount", int'(bus.hcount_out), 0);
        chk("reset_addr", int'(bus.pixel_addr), 0);
        rst = 1'b0;

        latch_pos(12'd100, 12'd50);
        foreach (vecs[i]) begin
            bus.hcount_in = vecs[i].h;
            bus.vcount_in = vecs[i].v;
            bus.hsync_in  = vecs[i].hs;
            bus.hblnk_in  = vecs[i].hb;
            bus.vblnk_in  = vecs[i].vb;
            bus.rgb_in    = vecs[i].rgb;
            rom_val       = vecs[i].rom;
            tick();
            if (vecs[i].chk_addr) chk($sformatf("vec%0d_addr", i), int'(bus.pixel_addr), int'(vecs[i].exp_addr));
            tick();
            chk($sformatf("vec%0d_rgb", i), int'(bus.rgb_out), int'(vecs[i].exp_rgb));
            chk($sformatf("vec%0d_hcount", i), int'(bus.hcount_out), int'(vecs[i].h));
            chk($sformatf("vec%0d_vcount", i), int'(bus.vcount_out), int'(vecs[i].v));
            chk($sformatf("vec%0d_hsync", i), int'(bus.hsync_out), int'(vecs[i].hs));
            chk($sformatf("vec%0d_hblnk", i), int'(bus.hblnk_out), int'(vecs[i].hb));
            chk($sformatf("vec%0d_vblnk", i), int'(bus.vblnk_out), int'(vecs[i].vb));
        end
        bus.hsync_in = 1'b0;

        // Back-to-back pixels across both rectangle edges
        sweep(60, 90, 175, 100, 50);

        // Mid-frame move is deferred to the next vsync rise
        bus.xpos = 12'd300;
        sweep(61, 90, 380, 100, 50);
        latch_pos(12'd300, 12'd50);
        sweep(61, 90, 380, 300, 50);

        // Clipping: far-right latch must not wrap, right-edge rectangle is cut at the line end
        latch_pos(12'hFF0, 12'd0);
        sweep(10, 0, 1023, 4080, 0);
        latch_pos(12'd760, 12'd0);
        sweep(10, 740, 799, 760, 0);

        // Mid-frame reset clears everything; rectangle falls back to the origin
        latch_pos(12'd100, 12'd50);
        bus.hcount_in = 11'd110;
        bus.vcount_in = 11'd60;
        bus.hsync_in  = 1'b1;
        bus.rgb_in    = 12'hABC;
        rom_val       = 12'h0F0;
        tick();
        tick();
        chk("pre_rst_rgb", int'(bus.rgb_out), 'h0F0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_rgb", int'(bus.rgb_out), 0);
        chk("rst_hcount", int'(bus.hcount_out), 0);
        chk("rst_vcount", int'(bus.vcount_out), 0);
        chk("rst_hsync", int'(bus.hsync_out), 0);
        chk("rst_addr", int'(bus.pixel_addr), 0);
        tick();
        chk("post_rst_1clk_hcount", int'(bus.hcount_out), 0);
        tick();
        chk("post_rst_2clk_hcount", int'(bus.hcount_out), 110);
        chk("post_rst_2clk_rgb", int'(bus.rgb_out), 'hABC);
        bus.hsync_in = 1'b0;
        sweep(5, 0, 70, 0, 0);

        // A vsync rise coincident with reset must not latch a new position
        bus.xpos     = 12'd300;
        bus.ypos     = 12'd200;
        bus.vsync_in = 1'b1;
        rst          = 1'b1;
        tick();
        rst          = 1'b0;
        bus.vsync_in = 1'b0;
        tick();
        sweep(5, 0, 70, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
